// File: rtl/shift_sched.sv
// Two-requester scheduler around one 32-bit logical right shifter.
// SLL, SRA and ROR are built from the right shift using bit reversal, a sign-fill mask and a two-pass rotate.
module shift_sched #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [SHW-1:0]   req0_shamt,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [SHW-1:0]   req1_shamt,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data
);
    localparam logic [1:0] OP_SRL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic {IDLE = 1'b0, ROT2 = 1'b1} state_t;

    state_t           stateReg;
    logic             lastGrantReg;
    logic             rspValidReg;
    logic             rspIdReg;
    logic [WIDTH-1:0] rspDataReg;
    logic [WIDTH-1:0] holdReg;
    logic [WIDTH-1:0] rotDataReg;
    logic [SHW-1:0]   rotShamtReg;
    logic             rotIdReg;

    logic             slotFree;
    logic             anyValid;
    logic             grantSel;
    logic [1:0]       selOp;
    logic [WIDTH-1:0] selData;
    logic [SHW-1:0]   selShamt;
    logic             selIsRor;
    logic             acceptOk;

    assign slotFree = !rspValidReg | rsp_ready;
    assign anyValid = req0_valid | req1_valid;
    // On contention the requester that did not win last time goes next.
    assign grantSel = (req0_valid & req1_valid) ? ~lastGrantReg : req1_valid;
    assign selOp    = grantSel ? req1_op    : req0_op;
    assign selData  = grantSel ? req1_data  : req0_data;
    assign selShamt = grantSel ? req1_shamt : req0_shamt;
    assign selIsRor = (selOp == OP_ROR);

    // A rotate only needs the shifter now; it checks the output slot in ROT2.
    assign acceptOk   = !reset & (stateReg == IDLE) & anyValid & (selIsRor | slotFree);
    assign req0_ready = acceptOk & ~grantSel;
    assign req1_ready = acceptOk & grantSel;

    logic [WIDTH-1:0] revSrc;
    logic [WIDTH-1:0] revIn;
    logic [WIDTH-1:0] shIn;
    logic [WIDTH-1:0] shOut;
    logic [WIDTH-1:0] revOut;
    logic [SHW:0]     shAmt;
    logic [WIDTH-1:0] fillMask;
    logic [WIDTH-1:0] idleResult;

    assign revSrc = (stateReg == ROT2) ? rotDataReg : selData;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
            assign revIn[gi]  = revSrc[WIDTH-1-gi];
            assign revOut[gi] = shOut[WIDTH-1-gi];
        end
    endgenerate

    always_comb begin
        shIn  = selData;
        shAmt = {1'b0, selShamt};
        if (stateReg == ROT2) begin
            // Second rotate pass is a left shift by WIDTH-shamt; a full-width shift yields zero.
            shIn  = revIn;
            shAmt = (SHW+1)'(WIDTH) - {1'b0, rotShamtReg};
        end else if (selOp == OP_SLL) begin
            shIn = revIn;
        end
    end

    assign shOut    = shIn >> shAmt;
    assign fillMask = selData[WIDTH-1] ? ~({WIDTH{1'b1}} >> selShamt) : '0;

    always_comb begin
        case (selOp)
            OP_SRL:  idleResult = shOut;
            OP_SLL:  idleResult = revOut;
            OP_SRA:  idleResult = shOut | fillMask;
            default: idleResult = shOut;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg     <= IDLE;
            lastGrantReg <= 1'b1;
            rspValidReg  <= 1'b0;
            rspIdReg     <= 1'b0;
            rspDataReg   <= '0;
            holdReg      <= '0;
            rotDataReg   <= '0;
            rotShamtReg  <= '0;
            rotIdReg     <= 1'b0;
        end else begin
            if (rspValidReg & rsp_ready)
                rspValidReg <= 1'b0;
            case (stateReg)
                IDLE: begin
                    if (acceptOk) begin
                        lastGrantReg <= grantSel;
                        if (selIsRor) begin
                            holdReg     <= shOut;
                            rotDataReg  <= selData;
                            rotShamtReg <= selShamt;
                            rotIdReg    <= grantSel;
                            stateReg    <= ROT2;
                        end else begin
                            rspValidReg <= 1'b1;
                            rspIdReg    <= grantSel;
                            rspDataReg  <= idleResult;
                        end
                    end
                end
                ROT2: begin
                    if (slotFree) begin
                        rspValidReg <= 1'b1;
                        rspIdReg    <= rotIdReg;
                        rspDataReg  <= holdReg | revOut;
                        stateReg    <= IDLE;
                    end
                end
                default: stateReg <= IDLE;
            endcase
        end
    end

    assign rsp_valid = rspValidReg;
    assign rsp_id    = rspIdReg;
    assign rsp_data  = rspDataReg;
endmodule

// File: tb/tb_shift_sched.sv
// Bench for shift_sched: directed scenarios plus a randomized run scored against
// an arithmetic shift/rotate model and an in-order response queue.
module tb_shift_sched;
    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]  req0_op, req1_op;
    logic [31:0] req0_data, req1_data;
    logic [4:0]  req0_shamt, req1_shamt;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_data;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    shift_sched #(.WIDTH(32), .SHW(5)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_data(req0_data), .req0_shamt(req0_shamt),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_data(req1_data), .req1_shamt(req1_shamt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
    );

    function automatic logic [31:0] refShift(input logic [1:0] op, input logic [31:0] d,
                                             input logic [4:0] s);
        logic [63:0] w;
        logic [31:0] r;
        case (op)
            2'd0: r = d >> s;
            2'd1: r = d << s;
            2'd2: r = $signed(d) >>> s;
            default: begin
                w = {d, d} >> s;
                r = w[31:0];
            end
        endcase
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit id, input bit v, input logic [1:0] op,
                         input logic [31:0] d, input logic [4:0] s);
        if (!id) begin
            req0_valid = v; req0_op = op; req0_data = d; req0_shamt = s;
        end else begin
            req1_valid = v; req1_op = op; req1_data = d; req1_shamt = s;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        rsp_ready = 1'b0;
        drive(0, 1, 2'd0, 32'hDEADBEEF, 5'd3);
        drive(1, 1, 2'd1, 32'h12345678, 5'd2);
        tick;
        tick;
        vecs++;
        if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_data !== 32'h0) begin
            errs++;
            $display("FAIL reset_rsp: got v=%b id=%b d=%h want v=0 id=0 d=00000000", rsp_valid, rsp_id, rsp_data);
        end
        vecs++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errs++;
            $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
        end
        drive(0, 0, 2'd0, 32'h0, 5'd0);
        drive(1, 0, 2'd0, 32'h0, 5'd0);
        rsp_ready = 1'b1;
        reset = 1'b0;
        tick;
    endtask

    task automatic test_single(input bit id, input logic [1:0] op, input logic [31:0] d,
                               input logic [4:0] s);
        logic [31:0] expv;
        logic        rdy;
        expv = refShift(op, d, s);
        rsp_ready = 1'b1;
        drive(id, 1, op, d, s);
        #1;
        rdy = id ? req1_ready : req0_ready;
        vecs++;
        if (rdy !== 1'b1) begin
            errs++;
            $display("FAIL single_ready: req%0d got %b want 1", id, rdy);
        end
        tick;
        drive(id, 0, op, d, s);
        if (op == 2'd3) begin
            drive(~id, 1, 2'd0, 32'hA5A5A5A5, 5'd1);
            #1;
            vecs++;
            if (rsp_valid !== 1'b0 || {req0_ready, req1_ready} !== 2'b00) begin
                errs++;
                $display("FAIL rot2_busy: got v=%b rdy=%b%b want v=0 rdy=00", rsp_valid, req0_ready, req1_ready);
            end
            drive(~id, 0, 2'd0, 32'h0, 5'd0);
            tick;
        end
        vecs++;
        if (rsp_valid !== 1'b1 || rsp_id !== id || rsp_data !== expv) begin
            errs++;
            $display("FAIL single_rsp op=%0d d=%h s=%0d: got v=%b id=%b d=%h want v=1 id=%0d d=%h",
                     op, d, s, rsp_valid, rsp_id, rsp_data, id, expv);
        end
        $display("txn req%0d op=%0d data=%h shamt=%0d -> %h", id, op, d, s, rsp_data);
        tick;
    endtask

    task automatic test_singles;
        test_single(0, 2'd0, 32'h80000000, 5'd4);
        test_single(0, 2'd1, 32'h00000001, 5'd31);
        test_single(0, 2'd2, 32'hF0000000, 5'd4);
        test_single(0, 2'd2, 32'h70000000, 5'd4);
        test_single(0, 2'd2, 32'h80000000, 5'd0);
        test_single(1, 2'd3, 32'h12345678, 5'd8);
        test_single(1, 2'd3, 32'h12345678, 5'd0);
        test_single(1, 2'd3, 32'h00000001, 5'd1);
        for (int i = 0; i < 8; i++)
            test_single(1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)), $urandom, 5'($urandom_range(31, 0)));
    endtask

    task automatic test_contention;
        logic [31:0] d0, d1, expv;
        logic [4:0]  s;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d0 = $urandom;
            d1 = $urandom;
            s  = 5'($urandom_range(31, 0));
            drive(0, 1, 2'd0, d0, s);
            drive(1, 1, 2'd0, d1, s);
            #1;
            vecs++;
            if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                errs++;
                $display("FAIL contend_grant cycle %0d: got %b%b want %s", i, req0_ready, req1_ready,
                         (i % 2 == 0) ? "10" : "01");
            end
            expv = ((i % 2 == 0) ? d0 : d1) >> s;
            tick;
            vecs++;
            if (rsp_valid !== 1'b1 || rsp_id !== 1'(i % 2) || rsp_data !== expv) begin
                errs++;
                $display("FAIL contend_rsp cycle %0d: got v=%b id=%b d=%h want v=1 id=%0d d=%h",
                         i, rsp_valid, rsp_id, rsp_data, i % 2, expv);
            end
            $display("txn contend cycle %0d id=%b data=%h", i, rsp_id, rsp_data);
        end
        drive(0, 0, 2'd0, 32'h0, 5'd0);
        drive(1, 0, 2'd0, 32'h0, 5'd0);
        tick;
    endtask

    task automatic test_backpressure;
        logic [31:0] dA, dB, expA, expB;
        dA = $urandom; dB = $urandom;
        expA = dA >> 3;
        expB = refShift(2'd1, dB, 5'd5);
        rsp_ready = 1'b1;
        drive(0, 1, 2'd0, dA, 5'd3);
        #1;
        tick;
        drive(0, 0, 2'd0, 32'h0, 5'd0);
        rsp_ready = 1'b0;
        drive(1, 1, 2'd1, dB, 5'd5);
        #1;
        for (int i = 0; i < 3; i++) begin
            vecs++;
            if ({req0_ready, req1_ready} !== 2'b00) begin
                errs++;
                $display("FAIL bp_ready cycle %0d: got %b%b want 00", i, req0_ready, req1_ready);
            end
            tick;
            vecs++;
            if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== expA) begin
                errs++;
                $display("FAIL bp_hold cycle %0d: got v=%b id=%b d=%h want v=1 id=0 d=%h",
                         i, rsp_valid, rsp_id, rsp_data, expA);
            end
        end
        rsp_ready = 1'b1;
        #1;
        vecs++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            errs++;
            $display("FAIL bp_release: got %b%b want 01", req0_ready, req1_ready);
        end
        tick;
        drive(1, 0, 2'd0, 32'h0, 5'd0);
        vecs++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== expB) begin
            errs++;
            $display("FAIL bp_next: got v=%b id=%b d=%h want v=1 id=1 d=%h", rsp_valid, rsp_id, rsp_data, expB);
        end
        $display("txn backpressure held=%h next=%h", expA, rsp_data);
        tick;
    endtask

    task automatic test_ror_stall;
        logic [31:0] dA, dR, expA, expR;
        logic [4:0]  sR;
        dA = $urandom; dR = $urandom; sR = 5'($urandom_range(31, 1));
        expA = dA >> 1;
        expR = refShift(2'd3, dR, sR);
        rsp_ready = 1'b1;
        drive(0, 1, 2'd0, dA, 5'd1);
        #1;
        tick;
        drive(0, 0, 2'd0, 32'h0, 5'd0);
        rsp_ready = 1'b0;
        drive(1, 1, 2'd3, dR, sR);
        #1;
        vecs++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            errs++;
            $display("FAIL stall_ror_accept: got %b%b want 01", req0_ready, req1_ready);
        end
        tick;
        drive(1, 0, 2'd0, 32'h0, 5'd0);
        drive(0, 1, 2'd0, 32'h0F0F0F0F, 5'd2);
        #1;
        for (int i = 0; i < 3; i++) begin
            vecs++;
            if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== expA || {req0_ready, req1_ready} !== 2'b00) begin
                errs++;
                $display("FAIL stall_rot2 cycle %0d: got v=%b id=%b d=%h rdy=%b%b want v=1 id=0 d=%h rdy=00",
                         i, rsp_valid, rsp_id, rsp_data, req0_ready, req1_ready, expA);
            end
            tick;
        end
        rsp_ready = 1'b1;
        #1;
        vecs++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errs++;
            $display("FAIL stall_release_ready: got %b%b want 00", req0_ready, req1_ready);
        end
        tick;
        vecs++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== expR) begin
            errs++;
            $display("FAIL stall_rsp: got v=%b id=%b d=%h want v=1 id=1 d=%h", rsp_valid, rsp_id, rsp_data, expR);
        end
        vecs++;
        if (req0_ready !== 1'b1) begin
            errs++;
            $display("FAIL stall_idle_again: req0_ready got %b want 1", req0_ready);
        end
        $display("txn ror stall data=%h shamt=%0d -> %h", dR, sR, rsp_data);
        drive(0, 0, 2'd0, 32'h0, 5'd0);
        tick;
    endtask

    task automatic test_reset_mid;
        logic [31:0] d0;
        rsp_ready = 1'b1;
        drive(0, 1, 2'd0, 32'hCAFEF00D, 5'd4);
        #1;
        tick;
        drive(0, 0, 2'd0, 32'h0, 5'd0);
        rsp_ready = 1'b0;
        drive(1, 1, 2'd3, 32'h89ABCDEF, 5'd12);
        #1;
        tick;
        drive(1, 0, 2'd0, 32'h0, 5'd0);
        vecs++;
        if (rsp_valid !== 1'b1) begin
            errs++;
            $display("FAIL rstmid_pre: rsp_valid got %b want 1", rsp_valid);
        end
        reset = 1'b1;
        d0 = $urandom;
        drive(0, 1, 2'd0, d0, 5'd7);
        drive(1, 1, 2'd0, 32'h11111111, 5'd1);
        tick;
        vecs++;
        if (rsp_valid !== 1'b0 || {req0_ready, req1_ready} !== 2'b00) begin
            errs++;
            $display("FAIL rstmid_clear: got v=%b rdy=%b%b want v=0 rdy=00", rsp_valid, req0_ready, req1_ready);
        end
        reset = 1'b0;
        rsp_ready = 1'b1;
        #1;
        vecs++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errs++;
            $display("FAIL rstmid_grant: got %b%b want 10", req0_ready, req1_ready);
        end
        tick;
        drive(0, 0, 2'd0, 32'h0, 5'd0);
        drive(1, 0, 2'd0, 32'h0, 5'd0);
        vecs++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== (d0 >> 7)) begin
            errs++;
            $display("FAIL rstmid_first: got v=%b id=%b d=%h want v=1 id=0 d=%h", rsp_valid, rsp_id, rsp_data, d0 >> 7);
        end
        tick;
    endtask

    task automatic test_random;
        bit          expId[$];
        logic [31:0] expData[$];
        bit          pend[2];
        logic [1:0]  pOp[2];
        logic [31:0] pData[2];
        logic [4:0]  pSh[2];
        bit          lastAcc, held, hId, accId, gotId;
        logic [31:0] hData, gotData;
        logic        r0, r1;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        lastAcc = 1'b1;
        pend[0] = 0; pend[1] = 0;
        for (int cyc = 0; cyc < 460; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && cyc < 400 && $urandom_range(1, 0) == 1) begin
                    pend[i]  = 1;
                    pOp[i]   = 2'($urandom_range(3, 0));
                    pData[i] = $urandom;
                    pSh[i]   = 5'($urandom_range(31, 0));
                end
                drive(1'(i), pend[i], pOp[i], pData[i], pSh[i]);
            end
            rsp_ready = (cyc < 400) ? ($urandom_range(3, 0) != 0) : 1'b1;
            #1;
            r0 = req0_ready;
            r1 = req1_ready;
            vecs++;
            if ((r0 & r1) || (r0 & !pend[0]) || (r1 & !pend[1])) begin
                errs++;
                $display("FAIL rand_ready_legal cycle %0d: got rdy=%b%b want at most one, only if valid (valid=%b%b)",
                         cyc, r0, r1, pend[0], pend[1]);
            end
            if (rsp_valid && rsp_ready) begin
                vecs++;
                if (expId.size() == 0) begin
                    errs++;
                    $display("FAIL rand_spurious cycle %0d: got rsp id=%b d=%h want no response", cyc, rsp_id, rsp_data);
                end else begin
                    gotId = expId.pop_front();
                    gotData = expData.pop_front();
                    if (rsp_id !== gotId || rsp_data !== gotData) begin
                        errs++;
                        $display("FAIL rand_rsp cycle %0d: got id=%b d=%h want id=%b d=%h",
                                 cyc, rsp_id, rsp_data, gotId, gotData);
                    end
                    $display("txn rand rsp id=%b data=%h", rsp_id, rsp_data);
                end
            end
            if (r0 | r1) begin
                accId = r1;
                if (pend[0] && pend[1]) begin
                    vecs++;
                    if (accId == lastAcc) begin
                        errs++;
                        $display("FAIL rand_fair cycle %0d: got grant %0d want %0d", cyc, accId, ~lastAcc);
                    end
                end
                lastAcc = accId;
                expId.push_back(accId);
                expData.push_back(refShift(pOp[accId], pData[accId], pSh[accId]));
                pend[accId] = 0;
            end
            held  = rsp_valid & !rsp_ready;
            hId   = rsp_id;
            hData = rsp_data;
            tick;
            if (held) begin
                vecs++;
                if (rsp_valid !== 1'b1 || rsp_id !== hId || rsp_data !== hData) begin
                    errs++;
                    $display("FAIL rand_stable cycle %0d: got v=%b id=%b d=%h want v=1 id=%b d=%h",
                             cyc, rsp_valid, rsp_id, rsp_data, hId, hData);
                end
            end
        end
        vecs++;
        if (expId.size() != 0 || pend[0] || pend[1] || rsp_valid !== 1'b0) begin
            errs++;
            $display("FAIL rand_drain: got %0d outstanding, pending=%b%b, rsp_valid=%b want none",
                     expId.size(), pend[0], pend[1], rsp_valid);
        end
        drive(0, 0, 2'd0, 32'h0, 5'd0);
        drive(1, 0, 2'd0, 32'h0, 5'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        rsp_ready = 1'b0;
        drive(0, 0, 2'd0, 32'h0, 5'd0);
        drive(1, 0, 2'd0, 32'h0, 5'd0);
        test_reset;
        test_singles;
        test_contention;
        test_backpressure;
        test_ror_stall;
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
